// File: rtl/spu_pipe_pkg.sv
// Shared definitions for the parametrised SPU execution pipe: packed-entry width,
// field offsets and the fill value returned for unit ids that have no unit behind them.
package spu_pipe_pkg;

   localparam int WR_OFS       = 0;
   localparam int LAT_OFS      = 1;
   localparam bit UID_ALL_ONES = 1'b1;

   function automatic int pack_w(int uid_w, int data_w, int addr_w, int lat_w);
      return uid_w + data_w + addr_w + lat_w + 1;
   endfunction

   function automatic int dst_ofs(int lat_w);
      return LAT_OFS + lat_w;
   endfunction

   function automatic int res_ofs(int lat_w, int addr_w);
      return dst_ofs(lat_w) + addr_w;
   endfunction

   function automatic int uid_ofs(int lat_w, int addr_w, int data_w);
      return res_ofs(lat_w, addr_w) + data_w;
   endfunction

endpackage

// File: rtl/spu_exec_pipe_param_if.sv
// Issue/flush inputs and stage/writeback outputs of the execution pipe.
interface spu_exec_pipe_param_if
   import spu_pipe_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 7,
   parameter int UID_W     = 3,
   parameter int NUM_UNITS = 4,
   parameter int LAT_W     = 4,
   parameter int DEPTH     = 7
);
   localparam int PACK_W = pack_w(UID_W, DATA_W, ADDR_W, LAT_W);

   logic                        issue_valid;
   logic [UID_W-1:0]            unit_id;
   logic [ADDR_W-1:0]           reg_dst;
   logic [LAT_W-1:0]            latency;
   logic                        reg_wr;
   logic [NUM_UNITS*DATA_W-1:0] unit_res;
   logic                        flush;
   logic [DEPTH*PACK_W-1:0]     stage_pack;
   logic [DEPTH-1:0]            stage_fwd_ok;
   logic [ADDR_W-1:0]           wb_addr;
   logic [DATA_W-1:0]           wb_data;
   logic                        wb_en;
   logic                        lat_err;
   logic [31:0]                 retire_cnt;

   modport master (
      output issue_valid, unit_id, reg_dst, latency, reg_wr, unit_res, flush,
      input  stage_pack, stage_fwd_ok, wb_addr, wb_data, wb_en, lat_err, retire_cnt
   );

   modport slave (
      input  issue_valid, unit_id, reg_dst, latency, reg_wr, unit_res, flush,
      output stage_pack, stage_fwd_ok, wb_addr, wb_data, wb_en, lat_err, retire_cnt
   );

endinterface

// File: rtl/spu_pipe_stage.sv
// One result-pipe stage: a packed-entry register whose write-enable bit can be
// killed on the way in, so a flushed entry keeps moving but can never write back.
module spu_pipe_stage
   import spu_pipe_pkg::*;
#(
   parameter int PACK_W = 144
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              kill,
   input  logic [PACK_W-1:0] d,
   output logic [PACK_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else
         q <= {d[PACK_W-1:WR_OFS+1], d[WR_OFS] & ~kill};
   end

endmodule

// File: rtl/spu_exec_pipe_param.sv
// Parametrised SPU execution pipe: unit-result select, DEPTH-stage result shift
// register with forward flags and young-stage flush, registered writeback.
module spu_exec_pipe_param
   import spu_pipe_pkg::*;
#(
   parameter int DATA_W    = 128,
   parameter int ADDR_W    = 7,
   parameter int UID_W     = 3,
   parameter int NUM_UNITS = 4,
   parameter int LAT_W     = 4,
   parameter int DEPTH     = 7,
   parameter int KILL_STG  = 2
) (
   input logic                  clk,
   input logic                  rst,
   spu_exec_pipe_param_if.slave bus
);
   localparam int PACK_W  = pack_w(UID_W, DATA_W, ADDR_W, LAT_W);
   localparam int DST_OFS = dst_ofs(LAT_W);
   localparam int RES_OFS = res_ofs(LAT_W, ADDR_W);

   logic [DATA_W-1:0] sel_res;
   logic [PACK_W-1:0] stg [DEPTH+1];

   always_comb begin
      sel_res = {DATA_W{UID_ALL_ONES}};
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (bus.unit_id == UID_W'(i))
            sel_res = bus.unit_res[(NUM_UNITS-1-i)*DATA_W +: DATA_W];
      end
   end

   // Slot 0 is the entry being issued; flush on stage 1 kills it.
   assign stg[0] = {bus.unit_id, sel_res, bus.reg_dst, bus.latency,
                    bus.reg_wr & bus.issue_valid};

   for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
      // Entry leaving stage k-1 is killed when stage k-1 lies inside the flush window.
      localparam bit KILLABLE = (k <= KILL_STG + 1);
      spu_pipe_stage #(.PACK_W(PACK_W)) u_stage (
         .clk  (clk),
         .rst  (rst),
         .kill (bus.flush & KILLABLE),
         .d    (stg[k-1]),
         .q    (stg[k])
      );
   end

   always_comb begin
      bus.stage_pack   = '0;
      bus.stage_fwd_ok = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         bus.stage_pack[(DEPTH-k)*PACK_W +: PACK_W] = stg[k];
         bus.stage_fwd_ok[k-1] = stg[k][WR_OFS] &&
                                 (LAT_W'(k) >= stg[k][LAT_OFS +: LAT_W]);
      end
   end

   // Writeback trails the last stage by one cycle; retire count tracks wb_en as it is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.wb_en      <= 1'b0;
         bus.wb_addr    <= '0;
         bus.wb_data    <= '0;
         bus.retire_cnt <= '0;
         bus.lat_err    <= 1'b0;
      end else begin
         bus.wb_en   <= stg[DEPTH][WR_OFS];
         bus.wb_addr <= stg[DEPTH][DST_OFS +: ADDR_W];
         bus.wb_data <= stg[DEPTH][RES_OFS +: DATA_W];
         if (stg[DEPTH][WR_OFS])
            bus.retire_cnt <= bus.retire_cnt + 32'd1;
         if (bus.issue_valid &&
             ((bus.latency == '0) || (bus.latency > LAT_W'(DEPTH))))
            bus.lat_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spu_exec_pipe_param.sv
// Directed self-checking bench for spu_exec_pipe_param with hand-computed expectations
// (DEPTH=7, KILL_STG=2, four 128-bit units).
module tb_spu_exec_pipe_param;
   localparam int DATA_W    = 128;
   localparam int ADDR_W    = 7;
   localparam int UID_W     = 3;
   localparam int NUM_UNITS = 4;
   localparam int LAT_W     = 4;
   localparam int DEPTH     = 7;
   localparam int KILL_STG  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] u0 = {16{8'h11}};
   logic [DATA_W-1:0] u1 = {16{8'hA5}};
   logic [DATA_W-1:0] u2 = {16{8'h3C}};
   logic [DATA_W-1:0] u3 = {16{8'h0F}};
   logic [DATA_W-1:0] allOnes = '1;
   logic [31:0]       expRetire = 0;

   spu_exec_pipe_param_if #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UID_W(UID_W),
      .NUM_UNITS(NUM_UNITS), .LAT_W(LAT_W), .DEPTH(DEPTH)
   ) bus ();

   spu_exec_pipe_param #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .UID_W(UID_W), .NUM_UNITS(NUM_UNITS),
      .LAT_W(LAT_W), .DEPTH(DEPTH), .KILL_STG(KILL_STG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic valid, input int uid, input int dst,
                                input int lat, input logic wr, input logic fl);
      bus.issue_valid = valid;
      bus.unit_id     = UID_W'(uid);
      bus.reg_dst     = ADDR_W'(dst);
      bus.latency     = LAT_W'(lat);
      bus.reg_wr      = wr;
      bus.flush       = fl;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 0, 0, 1, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] act,
                              input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   initial begin
      bus.unit_res = {u0, u1, u2, u3};
      applyIdle();
      tick(2);
      checkOutput("rst_stage_pack_zero", 128'(bus.stage_pack == '0), 128'd1);
      checkOutput("rst_wb_en", 128'(bus.wb_en), 128'd0);
      checkOutput("rst_lat_err", 128'(bus.lat_err), 128'd0);
      checkOutput("rst_retire", 128'(bus.retire_cnt), 128'd0);
      rst = 1'b0;

      // Single issue: forward flag at stage 3, writeback at cycle 8
      applyStimulus(1'b1, 1, 5, 3, 1'b1, 1'b0);
      tick(1);
      applyIdle();
      checkOutput("t1_fwd_c1", 128'(bus.stage_fwd_ok), 128'd0);
      tick(2);
      checkOutput("t1_fwd_c3", 128'(bus.stage_fwd_ok), 128'b0000100);
      tick(4);
      checkOutput("t1_wb_en_c7", 128'(bus.wb_en), 128'd0);
      tick(1);
      expRetire = 1;
      checkOutput("t1_wb_en_c8", 128'(bus.wb_en), 128'd1);
      checkOutput("t1_wb_addr", 128'(bus.wb_addr), 128'd5);
      checkOutput("t1_wb_data", 128'(bus.wb_data), 128'(u1));
      checkOutput("t1_retire", 128'(bus.retire_cnt), 128'(expRetire));
      tick(1);
      checkOutput("t1_wb_en_c9", 128'(bus.wb_en), 128'd0);

      // Back-to-back issue of dst 0..19
      for (int c = 0; c < 30; c++) begin
         if (c < 20)
            applyStimulus(1'b1, 2, c, 1, 1'b1, 1'b0);
         else
            applyIdle();
         tick(1);
         if (c + 1 >= 8 && c + 1 < 28) begin
            checkOutput("t2_wb_en", 128'(bus.wb_en), 128'd1);
            checkOutput("t2_wb_addr", 128'(bus.wb_addr), 128'(c + 1 - 8));
         end else begin
            checkOutput("t2_wb_en_idle", 128'(bus.wb_en), 128'd0);
         end
         if (c + 1 == 8)
            checkOutput("t2_wb_data", 128'(bus.wb_data), 128'(u2));
      end
      expRetire = 21;
      checkOutput("t2_retire", 128'(bus.retire_cnt), 128'(expRetire));

      // Flush: dst 12 (stage 2) and dst 3 (stage 1) killed, dst 4 issue killed
      applyStimulus(1'b1, 0, 10, 1, 1'b1, 1'b0); tick(1);
      applyStimulus(1'b1, 0, 11, 1, 1'b1, 1'b0); tick(1);
      applyStimulus(1'b1, 0, 12, 1, 1'b1, 1'b0); tick(1);
      applyStimulus(1'b1, 0, 3, 1, 1'b1, 1'b0);  tick(1);
      checkOutput("t3_fwd_pre_flush", 128'(bus.stage_fwd_ok), 128'b0001111);
      applyStimulus(1'b1, 0, 4, 1, 1'b1, 1'b1);  tick(1);
      applyIdle();
      checkOutput("t3_fwd_post_flush", 128'(bus.stage_fwd_ok), 128'b0011000);
      tick(3);
      expRetire = 22;
      checkOutput("t3_wb_en_10", 128'(bus.wb_en), 128'd1);
      checkOutput("t3_wb_addr_10", 128'(bus.wb_addr), 128'd10);
      tick(1);
      expRetire = 23;
      checkOutput("t3_wb_en_11", 128'(bus.wb_en), 128'd1);
      checkOutput("t3_wb_addr_11", 128'(bus.wb_addr), 128'd11);
      tick(1);
      checkOutput("t3_wb_en_12", 128'(bus.wb_en), 128'd0);
      checkOutput("t3_wb_addr_12", 128'(bus.wb_addr), 128'd12);
      tick(1);
      checkOutput("t3_wb_en_3", 128'(bus.wb_en), 128'd0);
      checkOutput("t3_wb_addr_3", 128'(bus.wb_addr), 128'd3);
      tick(1);
      checkOutput("t3_wb_en_4", 128'(bus.wb_en), 128'd0);
      checkOutput("t3_retire", 128'(bus.retire_cnt), 128'(expRetire));

      // Out-of-range unit id then last valid unit
      applyStimulus(1'b1, 6, 7, 2, 1'b1, 1'b0); tick(1);
      applyStimulus(1'b1, 3, 8, 2, 1'b1, 1'b0); tick(1);
      applyIdle();
      tick(6);
      checkOutput("t4_wb_en_oor", 128'(bus.wb_en), 128'd1);
      checkOutput("t4_wb_data_oor", 128'(bus.wb_data), 128'(allOnes));
      checkOutput("t4_wb_addr_oor", 128'(bus.wb_addr), 128'd7);
      tick(1);
      expRetire = 25;
      checkOutput("t4_wb_data_u3", 128'(bus.wb_data), 128'(u3));
      checkOutput("t4_retire", 128'(bus.retire_cnt), 128'(expRetire));

      // Latency error: invalid issue and lat=DEPTH do not set it; lat=0 and lat=9 do
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0); tick(1);
      checkOutput("t5_lat_err_novalid", 128'(bus.lat_err), 128'd0);
      applyStimulus(1'b1, 0, 0, 7, 1'b0, 1'b0); tick(1);
      checkOutput("t5_lat_err_lat7", 128'(bus.lat_err), 128'd0);
      applyStimulus(1'b1, 0, 0, 0, 1'b0, 1'b0); tick(1);
      applyIdle();
      checkOutput("t5_lat_err_lat0", 128'(bus.lat_err), 128'd1);
      tick(3);
      checkOutput("t5_lat_err_held", 128'(bus.lat_err), 128'd1);
      applyStimulus(1'b1, 0, 0, 9, 1'b0, 1'b0); tick(1);
      applyIdle();
      checkOutput("t5_lat_err_lat9", 128'(bus.lat_err), 128'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      expRetire = 0;
      checkOutput("t5_lat_err_rst", 128'(bus.lat_err), 128'd0);
      checkOutput("t5_retire_rst", 128'(bus.retire_cnt), 128'(expRetire));

      // Reset with four entries in flight discards them
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1, 20 + i, 1, 1'b1, 1'b0);
         tick(1);
      end
      applyIdle();
      checkOutput("t6_pre_rst_fwd", 128'(bus.stage_fwd_ok), 128'b0001111);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checkOutput("t6_stage_pack_zero", 128'(bus.stage_pack == '0), 128'd1);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         checkOutput("t6_wb_en", 128'(bus.wb_en), 128'd0);
      end
      checkOutput("t6_retire", 128'(bus.retire_cnt), 128'(expRetire));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
